// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic op_is_acc(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || op_is_acc(op);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider, one quotient bit per cycle on operand magnitudes,
// with sign fix-up applied to the final-step result.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             abort,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r, dz;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   tmp;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n;

  assign neg_a = sgn & dividend[WIDTH-1];
  assign neg_b = sgn & divisor[WIDTH-1];
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor : divisor;

  // rem < dvs always holds, so tmp - dvs fits in WIDTH bits when ge.
  // MIN / -1 falls out naturally: |MIN| / 1 = MIN after wrap, remainder 0.
  always_comb begin
    tmp       = {rem, quo[WIDTH-1]};
    ge        = tmp >= {1'b0, dvs};
    rem_n     = ge ? (tmp[WIDTH-1:0] - dvs) : tmp[WIDTH-1:0];
    quo_n     = {quo[WIDTH-2:0], ge};
    quotient  = neg_q ? -quo_n : quo_n;
    remainder = neg_r ? -rem_n : rem_n;
    done      = (cnt == CW'(1)) && !dz;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (load) begin
      cnt   <= CW'(WIDTH);
      rem   <= '0;
      quo   <= mag_a;
      dvs   <= mag_b;
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
      dz    <= (divisor == '0);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= rem_n;
      quo <= quo_n;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with HI/LO; results commit only on the final busy edge.
// MDU_MADD_EN adds the signed/unsigned multiply-accumulate ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state, state_nx;

  logic             is_mul, is_div, go, cnt_last;
  logic             mul_commit, div_commit;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic [WIDTH-1:0]   ma, mb;
  logic               msgn;
  logic [2*WIDTH-1:0] ea, eb, prod, mul_res;
`ifdef MDU_MADD_EN
  logic               macc, msub;
`endif

  assign is_mul   = op_is_mul(op);
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign go       = start && !flush && (state == ST_IDLE);
  assign cnt_last = (busy_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (go && is_mul)      state_nx = ST_MUL;
        else if (go && is_div) state_nx = ST_DIV;
      end
      ST_MUL, ST_DIV: if (flush || cnt_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    mul_commit = (state == ST_MUL) && cnt_last && !flush;
    div_commit = (state == ST_DIV) && cnt_last && !flush && div_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                busy_cnt <= '0;
    else if (flush)           busy_cnt <= '0;
    else if (go && is_mul)    busy_cnt <= CNT_W'(MULT_CYCLES);
    else if (go && is_div)    busy_cnt <= CNT_W'(WIDTH);
    else if (busy_cnt != '0)  busy_cnt <= busy_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ma   <= '0;
      mb   <= '0;
      msgn <= 1'b0;
`ifdef MDU_MADD_EN
      macc <= 1'b0;
      msub <= 1'b0;
`endif
    end else if (go && is_mul) begin
      ma   <= a;
      mb   <= b;
      msgn <= (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
`ifdef MDU_MADD_EN
      macc <= op_is_acc(op);
      msub <= (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    end
  end

  // Low 2*WIDTH bits of the extended product are correct for both signednesses.
  always_comb begin
    ea   = {{WIDTH{msgn & ma[WIDTH-1]}}, ma};
    eb   = {{WIDTH{msgn & mb[WIDTH-1]}}, mb};
    prod = ea * eb;
`ifdef MDU_MADD_EN
    // hi/lo cannot change while busy, so they still hold the start-time values.
    if (!macc)     mul_res = prod;
    else if (msub) mul_res = {hi, lo} - prod;
    else           mul_res = {hi, lo} + prod;
`else
    mul_res = prod;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (go && op == OP_MTHI) hi <= a;
      if (go && op == OP_MTLO) lo <= a;
      if (mul_commit) {hi, lo} <= mul_res;
      if (div_commit) begin
        hi <= div_rem;
        lo <= div_quo;
      end
    end
  end

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (go && is_div),
    .abort     (flush),
    .sgn       (op == OP_DIV),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: busy ops push expected hi/lo/busy length,
// a negedge monitor pops and compares when busy falls.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk, reset, start, flush, busy;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic [5:0]  busy_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  mdu_iter #(.WIDTH(32), .MULT_CYCLES(5), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .busy_cnt(busy_cnt), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = c; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) begin
      total++; bad++;
      $display("FAIL %s timeout: busy actual=1 expected=0", nm);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    logic prev;
    int   cyc;
    prev = 1'b0;
    cyc  = 0;
    forever begin
      @(negedge clk);
      if (busy) cyc++;
      else begin
        if (prev) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_op actual=busy_fall expected=none hi=%h lo=%h", hi, lo);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
            if (e.cyc >= 0) chk({e.name, "_cycles"}, 64'(cyc), 64'(e.cyc));
          end
        end
        cyc = 0;
      end
      prev = busy;
    end
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NONE; a = '0; b = '0;
    #12;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cnt", 64'(busy_cnt), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // MULT -2*3 with busy_cnt sequence
    push("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mult_cnt", 64'(busy_cnt), 64'(5 - i));
    end
    wait_idle("mult_neg");

    push("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 32);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg7_2");

    push("divu_by0", 32'hFFFFFFFF, 32'hFFFFFFFD, 32);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle("divu_by0");

    // MTHI then MTLO back to back
    start = 1'b1; op = OP_MTHI; a = 32'h1234;
    @(posedge clk); #1;
    op = OP_MTLO; a = 32'h5678;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo_keep", 64'(lo), 64'hFFFFFFFD);
    chk("mthi_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    chk("mtlo_lo", 64'(lo), 64'h5678);
    chk("mtlo_hi", 64'(hi), 64'h1234);
    chk("mtlo_busy", 64'(busy), 64'h0);

    // MADDU (feature dependent)
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
`ifdef MDU_MADD_EN
    push("maddu", 32'h1, 32'h0, 5);
    issue(OP_MADDU, 32'd1, 32'd1);
    wait_idle("maddu");
`else
    issue(OP_MADDU, 32'd1, 32'd1);
    chk("maddu_off_busy", 64'(busy), 64'h0);
    @(negedge clk);
    chk("maddu_off_hi", 64'(hi), 64'h0);
    chk("maddu_off_lo", 64'(lo), 64'hFFFFFFFF);
`endif
    issue(4'd15, 32'd3, 32'd3);
    chk("unknown_op_busy", 64'(busy), 64'h0);

    push("div_min_m1", 32'h0, 32'h80000000, 32);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_min_m1");

    push("divu_100_7", 32'd2, 32'd14, 32);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle("divu_100_7");

    push("multu_max", 32'hFFFFFFFE, 32'h00000001, 5);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu_max");

    // flush at busy_cnt == 2: aborted, hi/lo retained
    push("mult_flush", 32'hFFFFFFFE, 32'h00000001, 4);
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    chk("flush_at_cnt", 64'(busy_cnt), 64'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'h0);
    chk("flush_cnt", 64'(busy_cnt), 64'h0);
    @(negedge clk);

    // start together with flush launches nothing
    flush = 1'b1;
    issue(OP_MULT, 32'd5, 32'd5);
    chk("startflush_busy", 64'(busy), 64'h0);
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    flush = 1'b0;
    chk("startflush_mthi", 64'(hi), 64'hFFFFFFFE);
    chk("startflush_lo", 64'(lo), 64'h1);

    // start while busy is ignored
    push("mult_6_7", 32'h0, 32'h2A, 5);
    issue(OP_MULT, 32'd6, 32'd7);
    issue(OP_DIVU, 32'd9, 32'd3);
    wait_idle("mult_6_7");
    repeat (2) @(negedge clk);
    chk("ignored_start_busy", 64'(busy), 64'h0);

    // async reset mid-divide
    issue(OP_DIV, 32'd100, 32'd7);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_cnt != 6'd10 && n < 64);
    chk("div_reach_cnt10", 64'(busy_cnt), 64'd10);
    push("div_reset", 32'h0, 32'h0, -1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'h0);
    chk("async_rst_cnt", 64'(busy_cnt), 64'h0);
    chk("async_rst_hi", 64'(hi), 64'h0);
    chk("async_rst_lo", 64'(lo), 64'h0);
    #1 reset = 1'b0;
    @(negedge clk);

    push("div_7_neg2", 32'h1, 32'hFFFFFFFD, 32);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle("div_7_neg2");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
